// File: rtl/uart_avalon_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_avalon_ctrl
// Purpose  : Avalon-MM slave that fronts the UART core. Holds the TX and RX
//            FIFOs, the clk_gen baud divisor, control enables, sticky error
//            flags and a registered level interrupt.
// Ports    : clk, reset_n          - clock, async active-low reset
//            avs_*                 - Avalon-MM slave (read latency 1)
//            irq                   - registered level interrupt
//            clk_div               - baud divisor to clk_gen
//            tx_valid/tx_data/tx_ready/tx_done - core transmit handshake
//            rx_data/rx_done       - core receive strobe
// Revision : 1.0 - initial release
// ============================================================================
module uart_avalon_ctrl #(
  parameter int               TX_DEPTH = 16,
  parameter int               RX_DEPTH = 16,
  parameter int               DIV_W    = 16,
  parameter logic [DIV_W-1:0] DIV_RST  = 16'd434
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq,
  output logic [DIV_W-1:0] clk_div,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             tx_ready,
  input  logic             tx_done,
  input  logic [7:0]       rx_data,
  input  logic             rx_done
);

  localparam int TPW = $clog2(TX_DEPTH);
  localparam int RPW = $clog2(RX_DEPTH);
  localparam int TLW = TPW + 1;
  localparam int RLW = RPW + 1;

  // ---------------- state ----------------
  logic [7:0]       tx_mem_q [TX_DEPTH];
  logic [7:0]       rx_mem_q [RX_DEPTH];
  logic [TPW-1:0]   tx_wp_q, tx_rp_q, tx_wp_d, tx_rp_d;
  logic [RPW-1:0]   rx_wp_q, rx_rp_q, rx_wp_d, rx_rp_d;
  logic [TLW-1:0]   tx_lvl_q, tx_lvl_d;
  logic [RLW-1:0]   rx_lvl_q, rx_lvl_d;
  logic             tx_ovf_q, rx_ovr_q, tx_busy_q, irq_q, irq_d;
  logic [4:0]       ctrl_q;
  logic [DIV_W-1:0] div_q;
  logic [31:0]      rdata_q, rdata_d;

  // ---------------- bus decode ----------------
  logic wr_data, wr_status, wr_div, wr_ctrl, rd_strobe, rd_data;
  assign wr_data   = avs_write && (avs_address == 2'd0);
  assign wr_status = avs_write && (avs_address == 2'd1);
  assign wr_div    = avs_write && (avs_address == 2'd2);
  assign wr_ctrl   = avs_write && (avs_address == 2'd3);
  // A write on the same cycle as a read takes priority; the read is ignored.
  assign rd_strobe = avs_read && !avs_write;
  assign rd_data   = rd_strobe && (avs_address == 2'd0);

  // Upper write-data bits have no destination in this register map.
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata;

  // ---------------- FIFO flags and handshakes ----------------
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_pop, tx_push, tx_flush, rx_req, rx_pop, rx_push, rx_flush;

  assign tx_empty = (tx_lvl_q == '0);
  assign tx_full  = (tx_lvl_q == TLW'(TX_DEPTH));
  assign rx_empty = (rx_lvl_q == '0);
  assign rx_full  = (rx_lvl_q == RLW'(RX_DEPTH));

  assign tx_valid = ctrl_q[0] && !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;
  // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
  assign tx_push  = wr_data && (!tx_full || tx_pop);
  assign tx_flush = wr_ctrl && avs_writedata[5];

  assign rx_req   = rx_done && ctrl_q[1];
  assign rx_pop   = rd_data && !rx_empty;
  assign rx_push  = rx_req && (!rx_full || rx_pop);
  assign rx_flush = wr_ctrl && avs_writedata[6];

  // Show-ahead head byte; forced to zero while the FIFO is empty.
  assign tx_data = tx_empty ? 8'h00 : tx_mem_q[tx_rp_q];

  // ---------------- pointer / level next state ----------------
  always_comb begin
    tx_wp_d  = tx_push ? tx_wp_q + TPW'(1) : tx_wp_q;
    tx_rp_d  = tx_pop  ? tx_rp_q + TPW'(1) : tx_rp_q;
    tx_lvl_d = tx_lvl_q;
    if (tx_push && !tx_pop)      tx_lvl_d = tx_lvl_q + TLW'(1);
    else if (!tx_push && tx_pop) tx_lvl_d = tx_lvl_q - TLW'(1);
    // Flush overrides any push or pop in the same cycle.
    if (tx_flush) begin
      tx_wp_d  = '0;
      tx_rp_d  = '0;
      tx_lvl_d = '0;
    end

    rx_wp_d  = rx_push ? rx_wp_q + RPW'(1) : rx_wp_q;
    rx_rp_d  = rx_pop  ? rx_rp_q + RPW'(1) : rx_rp_q;
    rx_lvl_d = rx_lvl_q;
    if (rx_push && !rx_pop)      rx_lvl_d = rx_lvl_q + RLW'(1);
    else if (!rx_push && rx_pop) rx_lvl_d = rx_lvl_q - RLW'(1);
    if (rx_flush) begin
      rx_wp_d  = '0;
      rx_rp_d  = '0;
      rx_lvl_d = '0;
    end
  end

  // ---------------- read mux and interrupt ----------------
  always_comb begin
    rdata_d = '0;
    case (avs_address)
      2'd0: rdata_d = rx_empty ? 32'h0 : {1'b1, 23'b0, rx_mem_q[rx_rp_q]};
      2'd1: begin
        rdata_d[0]     = tx_full;
        rdata_d[1]     = tx_empty;
        rdata_d[2]     = rx_empty;
        rdata_d[3]     = rx_full;
        rdata_d[4]     = rx_ovr_q;
        rdata_d[5]     = tx_ovf_q;
        rdata_d[6]     = tx_empty && !tx_busy_q;
        rdata_d[15:8]  = 8'(tx_lvl_q);
        rdata_d[23:16] = 8'(rx_lvl_q);
      end
      2'd2:    rdata_d = 32'(div_q);
      default: rdata_d = {27'b0, ctrl_q};
    endcase
    irq_d = (ctrl_q[2] && !rx_empty) || (ctrl_q[3] && tx_empty) ||
            (ctrl_q[4] && (rx_ovr_q || tx_ovf_q));
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      tx_lvl_q  <= '0;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      rx_lvl_q  <= '0;
      tx_ovf_q  <= 1'b0;
      rx_ovr_q  <= 1'b0;
      tx_busy_q <= 1'b0;
      irq_q     <= 1'b0;
      ctrl_q    <= '0;
      div_q     <= DIV_RST;
      rdata_q   <= '0;
    end else begin
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_lvl_q <= tx_lvl_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_lvl_q <= rx_lvl_d;
      // Sticky flags: a new event in the same cycle as a W1C keeps the flag set.
      tx_ovf_q <= (tx_ovf_q && !(wr_status && avs_writedata[5])) ||
                  (wr_data && tx_full && !tx_pop);
      rx_ovr_q <= (rx_ovr_q && !(wr_status && avs_writedata[4])) ||
                  (rx_req && rx_full && !rx_pop);
      if (tx_pop)       tx_busy_q <= 1'b1;
      else if (tx_done) tx_busy_q <= 1'b0;
      irq_q <= irq_d;
      if (wr_ctrl)   ctrl_q  <= avs_writedata[4:0];
      if (wr_div)    div_q   <= avs_writedata[DIV_W-1:0];
      if (rd_strobe) rdata_q <= rdata_d;
    end
  end

  // FIFO storage needs no reset: levels gate every read of it.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= avs_writedata[7:0];
    if (rx_push) rx_mem_q[rx_wp_q] <= rx_data;
  end

  assign avs_readdata = rdata_q;
  assign irq          = irq_q;
  assign clk_div      = div_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_avalon_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_avalon_ctrl
// Purpose  : Scoreboard bench for uart_avalon_ctrl. Stimulus pushes expected
//            read data, handed-over TX bytes and per-cycle output values into
//            queues from a queue-based reference model; a monitor pops them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_avalon_ctrl;
  localparam int              TXD  = 16;
  localparam int              RXD  = 16;
  localparam int              DW   = 16;
  localparam logic [DW-1:0]   DRST = 16'd434;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    avs_address = '0;
  logic          avs_read = 1'b0, avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic [31:0]   avs_readdata;
  logic          irq;
  logic [DW-1:0] clk_div;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready = 1'b0, tx_done = 1'b0, rx_done = 1'b0;
  logic [7:0]    rx_data = '0;

  always #5 clk = ~clk;

  uart_avalon_ctrl #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .DIV_W(DW), .DIV_RST(DRST)) dut (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .irq(irq), .clk_div(clk_div), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_done(tx_done), .rx_data(rx_data), .rx_done(rx_done)
  );

  typedef struct { logic irq; logic txv; logic [DW-1:0] div; } cyc_t;
  cyc_t        exp_cyc[$];
  logic [31:0] exp_rd[$];
  logic [7:0]  exp_tx[$];

  // Reference model state
  logic [7:0]    m_tq[$], m_rq[$];
  logic          m_tx_ovf, m_rx_ovr, m_busy, m_irq;
  logic [4:0]    m_ctrl;
  logic [DW-1:0] m_div;

  int   checks = 0, errors = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_tq.delete(); m_rq.delete();
    m_tx_ovf = 0; m_rx_ovr = 0; m_busy = 0; m_irq = 0; m_ctrl = '0; m_div = DRST;
    exp_cyc.delete(); exp_rd.delete(); exp_tx.delete();
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s = '0;
    s[0] = (m_tq.size() == TXD);
    s[1] = (m_tq.size() == 0);
    s[2] = (m_rq.size() == 0);
    s[3] = (m_rq.size() == RXD);
    s[4] = m_rx_ovr;
    s[5] = m_tx_ovf;
    s[6] = (m_tq.size() == 0) && !m_busy;
    s[15:8]  = 8'(m_tq.size());
    s[23:16] = 8'(m_rq.size());
    return s;
  endfunction

  // One bus/core cycle: apply inputs, record expectations from the model's
  // current state, then advance the model to the state after the clock edge.
  task automatic drive(input logic rd, input logic wr, input logic [1:0] a, input logic [31:0] wd,
                       input logic trdy, input logic tdone, input logic rxd, input logic [7:0] rxb);
    logic hs, rpop, nirq;
    cyc_t c;
    @(negedge clk);
    avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = wd;
    tx_ready = trdy; tx_done = tdone; rx_done = rxd; rx_data = rxb;
    c.irq = m_irq; c.txv = m_ctrl[0] && (m_tq.size() != 0); c.div = m_div;
    exp_cyc.push_back(c);
    nirq = (m_ctrl[2] && m_rq.size() != 0) || (m_ctrl[3] && m_tq.size() == 0) ||
           (m_ctrl[4] && (m_rx_ovr || m_tx_ovf));
    hs = c.txv && trdy;
    if (hs) exp_tx.push_back(m_tq[0]);
    if (rd && !wr) begin
      case (a)
        2'd0:    exp_rd.push_back(m_rq.size() != 0 ? {1'b1, 23'b0, m_rq[0]} : 32'h0);
        2'd1:    exp_rd.push_back(m_status());
        2'd2:    exp_rd.push_back(32'(m_div));
        default: exp_rd.push_back({27'b0, m_ctrl});
      endcase
    end
    rpop = rd && !wr && (a == 2'd0) && (m_rq.size() != 0);
    if (wr && a == 2'd1) begin
      if (wd[4]) m_rx_ovr = 0;
      if (wd[5]) m_tx_ovf = 0;
    end
    if (hs) void'(m_tq.pop_front());
    if (wr && a == 2'd0) begin
      if (m_tq.size() < TXD) m_tq.push_back(wd[7:0]); else m_tx_ovf = 1;
    end
    if (hs) m_busy = 1; else if (tdone) m_busy = 0;
    if (rpop) void'(m_rq.pop_front());
    if (rxd && m_ctrl[1]) begin
      if (m_rq.size() < RXD) m_rq.push_back(rxb); else m_rx_ovr = 1;
    end
    if (wr && a == 2'd3) begin
      if (wd[5]) m_tq.delete();
      if (wd[6]) m_rq.delete();
      m_ctrl = wd[4:0];
    end
    if (wr && a == 2'd2) m_div = wd[DW-1:0];
    m_irq = nirq;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d); drive(0, 1, a, d, 0, 0, 0, 8'h0); endtask
  task automatic rdr(input logic [1:0] a); drive(1, 0, a, 32'h0, 0, 0, 0, 8'h0); endtask
  task automatic idle(); drive(0, 0, 2'd0, 32'h0, 0, 0, 0, 8'h0); endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_irq"}, 32'(irq), 32'h0);
    chk({tag, "_tx_valid"}, 32'(tx_valid), 32'h0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'h0);
    chk({tag, "_clk_div"}, 32'(clk_div), 32'(DRST));
    chk({tag, "_readdata"}, avs_readdata, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    avs_read = 0; avs_write = 0; tx_ready = 0; tx_done = 0; rx_done = 0;
    #3 reset_n = 1'b0;
    #1 check_reset_outputs("midreset");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Monitor: compares DUT outputs against queued expectations.
  initial begin
    logic prev_rd;
    cyc_t c;
    logic [31:0] e;
    logic [7:0]  b;
    prev_rd = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n || !mon_en) begin
        prev_rd = 1'b0;
      end else begin
        if (prev_rd) begin
          if (exp_rd.size() == 0) chk("rd_unexpected", avs_readdata, 32'hDEAD_BEEF);
          else begin
            e = exp_rd.pop_front();
            chk("readdata", avs_readdata, e);
          end
        end
        prev_rd = avs_read && !avs_write;
        if (exp_cyc.size() != 0) begin
          c = exp_cyc.pop_front();
          chk("irq", 32'(irq), 32'(c.irq));
          chk("tx_valid", 32'(tx_valid), 32'(c.txv));
          chk("clk_div", 32'(clk_div), 32'(c.div));
        end
        if (tx_valid && tx_ready) begin
          if (exp_tx.size() == 0) chk("tx_unexpected_handover", 32'(tx_data), 32'h100);
          else begin
            b = exp_tx.pop_front();
            chk("tx_data", 32'(tx_data), 32'(b));
          end
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Reset status
    rdr(2'd1); rdr(2'd2); rdr(2'd3);

    // Two-byte transmit with core handshakes and frame-done pulses
    wr(2'd3, 32'h1); wr(2'd0, 32'h55); wr(2'd0, 32'hA3); rdr(2'd1);
    drive(0, 0, 2'd0, 0, 1, 0, 0, 8'h0); idle(); rdr(2'd1);
    drive(0, 0, 2'd0, 0, 0, 1, 0, 8'h0); rdr(2'd1);
    drive(0, 0, 2'd0, 0, 1, 0, 0, 8'h0); idle(); rdr(2'd1);
    drive(0, 0, 2'd0, 0, 0, 1, 0, 8'h0); rdr(2'd1);

    // TX overflow and W1C
    wr(2'd3, 32'h0);
    for (int i = 0; i < 17; i++) wr(2'd0, 32'(i + 8'h10));
    rdr(2'd1); wr(2'd1, 32'h20); rdr(2'd1);

    // RX with interrupt (also flushes the full TX FIFO)
    wr(2'd3, 32'h26); rdr(2'd3);
    drive(0, 0, 2'd0, 0, 0, 0, 1, 8'h3C); idle(); idle();
    rdr(2'd0); rdr(2'd0); idle(); idle();

    // RX full: simultaneous receive and pop, then a real overrun
    wr(2'd3, 32'h2);
    for (int i = 0; i < 16; i++) drive(0, 0, 2'd0, 0, 0, 0, 1, 8'(8'hC0 + i));
    rdr(2'd1);
    drive(1, 0, 2'd0, 0, 0, 0, 1, 8'hEE); rdr(2'd1);
    drive(0, 0, 2'd0, 0, 0, 0, 1, 8'h77); rdr(2'd1);
    wr(2'd1, 32'h10); rdr(2'd1); wr(2'd3, 32'h40); rdr(2'd1);

    // TX flush with bytes queued, clock divisor write
    wr(2'd3, 32'h0);
    for (int i = 0; i < 5; i++) wr(2'd0, 32'(8'hA0 + i));
    wr(2'd3, 32'h20); rdr(2'd1); rdr(2'd3);
    wr(2'd2, 32'h0000_1234); rdr(2'd2);

    // Reset in the middle of a frame
    wr(2'd3, 32'h1F); wr(2'd0, 32'h11); wr(2'd0, 32'h22);
    drive(0, 0, 2'd0, 0, 1, 0, 0, 8'h0);
    do_reset();
    rdr(2'd1); rdr(2'd2);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [1:0]  op, a;
      logic [31:0] wd;
      op = 2'($urandom_range(0, 3));
      a  = 2'($urandom_range(0, 3));
      wd = $urandom;
      if (a == 2'd3 && $urandom_range(0, 7) != 0) wd[6:5] = 2'b00;
      drive(op == 2'd1, op >= 2'd2, a, wd, 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 8'($urandom));
    end

    idle(); idle(); idle();
    @(negedge clk);
    #2;
    chk("rd_queue_drained", 32'(exp_rd.size()), 32'h0);
    chk("tx_queue_drained", 32'(exp_tx.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_avalon_ctrl.md
Name: uart_avalon_ctrl

Overview:
- Avalon-MM slave controller that sequences the UART core and exposes it to the bus.
- Owns a TX FIFO and an RX FIFO, the baud divisor register for clk_gen, enables, sticky error flags and the interrupt.
- Sits between the Avalon interconnect and uart_core/clk_gen inside the UART slave.
- All core-side handshake signals are in the clk domain; uart_core runs from a clk_gen clock-enable.

Parameters:
- TX_DEPTH, 16, TX FIFO entries; power of 2, min 2.
- RX_DEPTH, 16, RX FIFO entries; power of 2, min 2.
- DIV_W, 16, clk_div width.
- DIV_RST, 16'd434, clk_div reset value.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- avs_address  in  2  register index: 0 DATA, 1 STATUS, 2 CLKDIV, 3 CTRL.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, valid 1 cycle after avs_read.
- irq  out  1  level interrupt, registered.
- clk_div  out  DIV_W  divisor to clk_gen.
- tx_valid  out  1  TX byte available to core.
- tx_data  out  8  TX byte, head of TX FIFO (show-ahead).
- tx_ready  in  1  core accepts byte when tx_valid&&tx_ready.
- tx_done  in  1  1-cycle pulse, frame finished on the line.
- rx_data  in  8  received byte, valid with rx_done.
- rx_done  in  1  1-cycle pulse, byte received.

Behaviour:
- Reset: all outputs 0 except clk_div=DIV_RST; FIFOs empty; CTRL=0; sticky flags 0; tx_busy 0.
- Clock and reset: one clock (clk); reset_n is asynchronous assert, active-low. Reset mid-frame discards both FIFOs' contents; no drain.
- Bus timing: no waitrequest. Fixed read latency 1: avs_readdata is registered and holds its value until the next read. Simultaneous avs_read and avs_write are illegal; write wins.
- DATA write: pushes writedata[7:0] into the TX FIFO. If full, the byte is dropped and tx_ovf is set.
- DATA read: returns {rx_nonempty at bit31, 23'b0, head byte}; if nonempty, pops. If empty, returns 0 and does not pop.
- STATUS read:
  - bit0 tx_full, bit1 tx_empty, bit2 rx_empty, bit3 rx_full, bit4 rx_ovr, bit5 tx_ovf, bit6 tx_idle.
  - [15:8] tx_level, [23:16] rx_level, rest 0.
- STATUS write: W1C on bits 4/5; other bits are ignored.
- CLKDIV: R/W [DIV_W-1:0]; a write takes effect next cycle. Software changes it only when tx_idle.
- CTRL: bit0 tx_en, bit1 rx_en, bit2 rx_ie, bit3 tx_ie, bit4 err_ie are R/W.
  - bit5 tx_flush and bit6 rx_flush are write-1 self-clearing: empty the FIFO that cycle and read back 0.
- TX sequencing:
  - tx_valid = tx_en && !tx_empty.
  - On tx_valid&&tx_ready: pop, set tx_busy.
  - tx_done clears tx_busy unless a new handshake occurs in the same cycle.
  - tx_idle = tx_empty && !tx_busy.
  - Clearing tx_en holds the FIFO; a frame already handed over completes.
- RX: on rx_done && rx_en, push rx_data. If full, the byte is dropped and rx_ovr is set. rx_done with !rx_en is ignored, no flag.
- Simultaneous push/pop on the same FIFO:
  - Level unchanged; legal even when full (pop frees the slot first) or empty.
  - On empty, push and read-pop in the same cycle: the read returns empty; the byte stays.
- Flush coincident with a push: flush wins; the FIFO ends empty.
- Levels: width clog2(DEPTH)+1, range 0..DEPTH; pointers wrap modulo DEPTH.
- irq is registered, 1-cycle lag: (rx_ie && !rx_empty) || (tx_ie && tx_empty) || (err_ie && (rx_ovr||tx_ovf)).

Test Plan:
- Reset -> clk_div=434, STATUS reads 0x00000046 (tx_empty, rx_empty, tx_idle), irq=0, tx_valid=0.
- CTRL=0x1, write DATA 0x55,0xA3; core tx_ready=1 one cycle each, tx_done after each -> tx_data 0x55 then 0xA3; STATUS bit6 =1 only after second tx_done.
- tx_en=0, write 17 bytes (TX_DEPTH=16) -> tx_level=16, tx_full=1, tx_ovf=1; STATUS write 0x20 -> tx_ovf=0; level still 16.
- rx_en=1, rx_ie=1; pulse rx_done with 0x3C -> irq=1 two cycles later; DATA read -> 0x8000003C, next read -> 0x00000000, irq drops.
- RX FIFO full, rx_done and DATA read in the same cycle -> no overrun, rx_level stays 16, oldest byte returned.
- Write CTRL bit5 with 5 bytes queued -> tx_level=0 next cycle, CTRL readback bit5=0; assert reset_n low mid-frame -> all outputs at reset values immediately.
